wb_write_queue: RTL and testbench

Writeback write queue: the writer side of the CPU register file. It accepts register-write requests from the writeback stage into a small in-order FIFO. It drains one entry per cycle onto the register file's single write port (RegWrite / writeReg / writeData). It also provides a youngest-match bypass lookup, so decode can see values that are queued but not yet written.

---
 rtl/wb_write_queue.sv | 96 +++++++++
 tb/tb_wb_write_queue.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Writeback write queue: in-order FIFO in front of the register file's single
// write port, with a youngest-match bypass lookup for the decode stage.
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_rd,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     rf_RegWrite,
  output logic [ADDR_W-1:0]        rf_writeReg,
  output logic [DATA_W-1:0]        rf_writeData,
  input  logic [ADDR_W-1:0]        q_reg1,
  input  logic [ADDR_W-1:0]        q_reg2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [DATA_W-1:0]        hit_data1,
  output logic [DATA_W-1:0]        hit_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_push, w_pop, w_active;
  logic [DATA_W:0]   w_byp1, w_byp2;

  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign in_ready = rst && !full;

  // Outputs are also gated by reset so nothing queued leaks out during the reset cycle.
  assign w_active     = rst && !empty;
  assign rf_RegWrite  = w_active && drain_en;
  assign rf_writeReg  = w_active ? r_rd[r_rptr]   : '0;
  assign rf_writeData = w_active ? r_data[r_rptr] : '0;

  // Writes to x0 complete the handshake but are dropped.
  assign w_push = in_valid && in_ready && (in_rd != '0);
  assign w_pop  = rf_RegWrite;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= in_rd;
      r_data[r_wptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk entries oldest to youngest so the last match (youngest) wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] q);
    logic [DATA_W:0] res;
    logic [PW-1:0]   idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_rptr + PW'(i);
      if (rst && (q != '0) && (CW'(i) < r_count) && (r_rd[idx] == q))
        res = {1'b1, r_data[idx]};
    end
    return res;
  endfunction

  always_comb begin
    w_byp1 = lookup(q_reg1);
    w_byp2 = lookup(q_reg2);
  end

  assign {hit1, hit_data1} = w_byp1;
  assign {hit2, hit_data2} = w_byp2;
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: driver pushes expected writes into a
// scoreboard queue, a negedge monitor pops and compares every register-file write.
module tb_wb_write_queue;
  localparam int DEPTH = 4, ADDR_W = 5, DATA_W = 32;

  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, drain_en = 0;
  logic [ADDR_W-1:0] in_rd = '0, q_reg1 = '0, q_reg2 = '0, rf_writeReg;
  logic [DATA_W-1:0] in_data = '0, rf_writeData, hit_data1, hit_data2;
  logic rf_RegWrite, hit1, hit2, empty, full;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed { logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data; } wr_t;
  wr_t exp_q[$];
  int n_checks = 0, n_err = 0;
  bit chk_occ = 0;

  wb_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_data(in_data), .drain_en(drain_en), .rf_RegWrite(rf_RegWrite),
    .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData), .q_reg1(q_reg1),
    .q_reg2(q_reg2), .hit1(hit1), .hit2(hit2), .hit_data1(hit_data1),
    .hit_data2(hit_data2), .count(count), .empty(empty), .full(full));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every asserted write must match the oldest outstanding expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (chk_occ) chk("occupancy<=1", 64'(count <= 1), 64'd1);
      if (rf_RegWrite) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_write: got rd=%0d data=%0h expected none", rf_writeReg, rf_writeData);
        end else begin
          e = exp_q.pop_front();
          chk("wr_rd", 64'(rf_writeReg), 64'(e.rd));
          chk("wr_data", 64'(rf_writeData), 64'(e.data));
        end
      end
    end
  end

  // One handshake; expectation queued when issued (x0 writes expect nothing).
  task automatic send(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
    int t = 0;
    in_valid = 1; in_rd = rd; in_data = data;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("send_timeout", 64'd0, 64'd1);
    if (rd != 0) exp_q.push_back('{rd: rd, data: data});
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_empty();
    int t = 0;
    @(negedge clk);
    while (!empty && t < 100) begin @(negedge clk); t++; end
    chk("drain_timeout", 64'(t < 100), 64'd1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_count", 64'(count), 0); chk("rst_empty", 64'(empty), 1);
    chk("rst_full", 64'(full), 0);   chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_regwrite", 64'(rf_RegWrite), 0); chk("rst_writereg", 64'(rf_writeReg), 0);
    chk("rst_writedata", 64'(rf_writeData), 0); chk("rst_hit1", 64'(hit1), 0);
    chk("rst_hit_data1", 64'(hit_data1), 0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk); chk("in_ready_after_rst", 64'(in_ready), 1);

    // Single push, immediate drain, bypass visible for one cycle
    @(posedge clk); #1;
    drain_en = 1; q_reg1 = 3;
    send(5'd3, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_regwrite", 64'(rf_RegWrite), 1); chk("t1_writereg", 64'(rf_writeReg), 3);
    chk("t1_writedata", 64'(rf_writeData), 64'hDEADBEEF);
    chk("t1_hit1", 64'(hit1), 1); chk("t1_hit_data1", 64'(hit_data1), 64'hDEADBEEF);
    @(negedge clk);
    chk("t1_empty", 64'(empty), 1); chk("t1_hit1_gone", 64'(hit1), 0);

    // Fill to full, hold rd=5, release by draining
    @(posedge clk); #1 drain_en = 0;
    for (int i = 1; i <= 4; i++) send(5'(i), 32'h100 + i);
    in_valid = 1; in_rd = 5; in_data = 32'h105;
    @(negedge clk);
    chk("t2_full", 64'(full), 1); chk("t2_in_ready", 64'(in_ready), 0);
    chk("t2_count", 64'(count), 4);
    @(negedge clk); chk("t2_held", 64'(in_ready), 0);
    @(posedge clk); #1 drain_en = 1;
    @(negedge clk);
    chk("t2_ready_at_first_pop", 64'(in_ready), 0);
    exp_q.push_back('{rd: 5'd5, data: 32'h105});
    @(negedge clk);
    chk("t2_ready_after_pop", 64'(in_ready), 1); chk("t2_count_after_pop", 64'(count), 3);
    @(posedge clk); #1 in_valid = 0;
    wait_empty();

    // Same rd twice: youngest on bypass, arrival order on drain
    @(posedge clk); #1 drain_en = 0; q_reg1 = 7; q_reg2 = 7;
    send(5'd7, 32'h11);
    send(5'd7, 32'h22);
    @(negedge clk);
    chk("t3_count", 64'(count), 2); chk("t3_hit1", 64'(hit1), 1);
    chk("t3_hit_data1", 64'(hit_data1), 64'h22); chk("t3_hit_data2", 64'(hit_data2), 64'h22);
    @(posedge clk); #1 drain_en = 1;
    wait_empty();

    // x0 filter
    @(posedge clk); #1 q_reg1 = 0; q_reg2 = 0;
    send(5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("t4_count", 64'(count), 0); chk("t4_regwrite", 64'(rf_RegWrite), 0);
    chk("t4_hit1", 64'(hit1), 0);

    // Reset discards queued entries
    @(posedge clk); #1 drain_en = 0; q_reg1 = 9;
    send(5'd9, 32'h909); send(5'd10, 32'hA0A); send(5'd11, 32'hB0B);
    @(negedge clk); chk("t5_count", 64'(count), 3); chk("t5_hit1", 64'(hit1), 1);
    @(posedge clk); #1 rst = 0; drain_en = 1;
    exp_q.delete();
    @(negedge clk);
    chk("t5_rst_regwrite", 64'(rf_RegWrite), 0); chk("t5_rst_in_ready", 64'(in_ready), 0);
    chk("t5_rst_hit1", 64'(hit1), 0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("t5_count0", 64'(count), 0); chk("t5_empty", 64'(empty), 1);
    chk("t5_regwrite0", 64'(rf_RegWrite), 0); chk("t5_hit1_0", 64'(hit1), 0);
    repeat (3) @(negedge clk);

    // Back-to-back pushes with continuous drain, wraps pointers
    @(posedge clk); #1 drain_en = 1; chk_occ = 1;
    for (int i = 0; i < 2 * DEPTH + 3; i++) send(5'(i + 1), 32'hA000_0000 + i);
    wait_empty();
    chk_occ = 0;

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
